if_id_fetch_queue: RTL

//   Decoupling queue between the IF stage and the ID stage of the MUSA core.

---
 rtl/if_id_fetch_queue_pkg.sv | 14 +
 rtl/if_id_fetch_queue_mem.sv | 23 ++
 rtl/if_id_fetch_queue.sv | 82 ++++++++
 3 files changed

// File: rtl/if_id_fetch_queue_pkg.sv
// if_id_fetch_queue_pkg: shared MUSA fetch-path constants and the IF/ID entry type
package if_id_fetch_queue_pkg;

    localparam int WORD_W = 32;

    // sll $0,$0,0 -- the canonical MIPS no-op, fed to ID when the queue is empty
    localparam logic [WORD_W-1:0] NOP_INSTR = 32'h0000_0000;

    typedef struct packed {
        logic [WORD_W-1:0] pc;
        logic [WORD_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/if_id_fetch_queue_mem.sv
// if_id_fetch_queue_mem: DEPTH x W register array, one sync write port, one async read port
module if_id_fetch_queue_mem #(
    parameter int DEPTH = 4,
    parameter int W     = 64
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [W-1:0]             wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [W-1:0]             rdata
);

    logic [W-1:0] mem [DEPTH];

    // storage is deliberately not reset; validity is tracked by the occupancy count
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/if_id_fetch_queue.sv
// if_id_fetch_queue: IF->ID decoupling FIFO with NOP bubble on empty and flush on taken branch
module if_id_fetch_queue
    import if_id_fetch_queue_pkg::*;
#(
    parameter int                   DEPTH     = 4,
    parameter int                   WORD_W    = if_id_fetch_queue_pkg::WORD_W,
    parameter logic [WORD_W-1:0]    NOP_INSTR = if_id_fetch_queue_pkg::NOP_INSTR
) (
    input  logic                       _clk,
    input  logic                       _reset,
    input  logic                       if_valid,
    input  logic [WORD_W-1:0]          if_pc,
    input  logic [WORD_W-1:0]          if_instr,
    output logic                       if_ready,
    input  logic                       flush,
    input  logic                       id_stall,
    output logic                       id_valid,
    output logic [WORD_W-1:0]          id_pc,
    output logic [WORD_W-1:0]          id_instr,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [WORD_W-1:0] pc;
        logic [WORD_W-1:0] instr;
    } entry_t;

    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [CW-1:0] count_q;
    logic          push;
    logic          pop;
    entry_t        wr_entry;
    entry_t        rd_entry;

    // ready and valid depend only on occupancy, so IF never sees a comb path from id_stall
    assign if_ready = count_q != CW'(DEPTH);
    assign id_valid = count_q != '0;
    assign push     = if_valid & if_ready & ~flush;
    assign pop      = id_valid & ~id_stall & ~flush;
    assign count    = count_q;
    assign wr_entry = '{pc: if_pc, instr: if_instr};

    // flush wins over push/pop; pointers wrap through natural AW-bit overflow
    always_ff @(posedge _clk or negedge _reset) begin
        if (!_reset) begin
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
        end else if (flush) begin
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
        end else begin
            head    <= head + AW'(pop);
            tail    <= tail + AW'(push);
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end

    if_id_fetch_queue_mem #(
        .DEPTH (DEPTH),
        .W     (2 * WORD_W)
    ) u_mem (
        .clk   (_clk),
        .we    (push),
        .waddr (tail),
        .wdata (wr_entry),
        .raddr (head),
        .rdata (rd_entry)
    );

    // head entry goes straight to ID; an empty queue presents a NOP bubble with pc 0
    always_comb begin
        id_pc    = id_valid ? rd_entry.pc    : '0;
        id_instr = id_valid ? rd_entry.instr : NOP_INSTR;
    end

endmodule
